// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and default widths for the memory burst arbiter.
package mem_arb_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_LEN_W  = 10;
  localparam int NUM_SRC    = 4;

  // Grant index layout matches the request vector {rd1,rd0,wr1,wr0}.
  localparam logic [1:0] GNT_WR0 = 2'd0;
  localparam logic [1:0] GNT_WR1 = 2'd1;
  localparam logic [1:0] GNT_RD0 = 2'd2;
  localparam logic [1:0] GNT_RD1 = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_DONE} arb_state_t;

  function automatic logic [1:0] gnt_onehot(input logic [1:0] g);
    return g[0] ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin pick over four requesters, searching upward from i_last+1 with wrap.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [1:0]         i_last,
  output logic [1:0]         o_gnt,
  output logic               o_vld
);
  logic [1:0] w_idx;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_gnt = i_last;
    o_vld = 1'b0;
    w_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_idx = i_last + 2'(k);
      if (i_req[w_idx]) begin
        o_gnt = w_idx;
        o_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_burst_arbiter.sv
// Two-writer / two-reader burst arbiter in front of a single memory burst engine.
// Optional macro ARB_RD0_PRIORITY_EN gives rd0 absolute priority at arbitration.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                mem_clk,
  input  logic                rst,
  input  logic [1:0]          c_wr_req,
  input  logic [1:0]          c_rd_req,
  input  logic [2*LEN_W-1:0]  c_wr_len,
  input  logic [2*LEN_W-1:0]  c_rd_len,
  input  logic [2*ADDR_W-1:0] c_wr_addr,
  input  logic [2*ADDR_W-1:0] c_rd_addr,
  input  logic [2*DATA_W-1:0] c_wr_data,
  output logic [1:0]          c_wr_data_req,
  output logic [1:0]          c_rd_data_valid,
  output logic [DATA_W-1:0]   c_rd_data,
  output logic [1:0]          c_wr_finish,
  output logic [1:0]          c_rd_finish,
  output logic                m_wr_burst_req,
  output logic                m_rd_burst_req,
  output logic [LEN_W-1:0]    m_wr_burst_len,
  output logic [LEN_W-1:0]    m_rd_burst_len,
  output logic [ADDR_W-1:0]   m_wr_burst_addr,
  output logic [ADDR_W-1:0]   m_rd_burst_addr,
  output logic [DATA_W-1:0]   m_wr_burst_data,
  input  logic                m_wr_burst_data_req,
  input  logic                m_rd_burst_data_valid,
  input  logic                m_wr_burst_finish,
  input  logic                m_rd_burst_finish,
  input  logic [DATA_W-1:0]   m_rd_burst_data,
  output logic                busy,
  output logic [1:0]          grant_id
);
  arb_state_t        r_state, w_state_nxt;
  logic [1:0]        r_grant, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;

  logic [NUM_SRC-1:0] w_req;
  logic [1:0]         w_rr_gnt, w_pick;
  logic               w_rr_vld, w_upd_last;
  logic [ADDR_W-1:0]  w_pick_addr;
  logic [LEN_W-1:0]   w_pick_len;
  logic               w_rd, w_active, w_in_busy, w_in_done, w_fin, w_nz;

  assign w_req = {c_rd_req, c_wr_req};

  mem_arb_rr u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt),
    .o_vld  (w_rr_vld)
  );

  // A priority rd0 grant leaves last_grant alone so rotation among the rest resumes.
  always_comb begin
    w_pick     = w_rr_gnt;
    w_upd_last = 1'b1;
`ifdef ARB_RD0_PRIORITY_EN
    if (w_req[GNT_RD0]) begin
      w_pick     = GNT_RD0;
      w_upd_last = 1'b0;
    end
`endif
  end

  always_comb begin
    if (w_pick[1]) begin
      w_pick_addr = w_pick[0] ? c_rd_addr[2*ADDR_W-1:ADDR_W] : c_rd_addr[ADDR_W-1:0];
      w_pick_len  = w_pick[0] ? c_rd_len[2*LEN_W-1:LEN_W]    : c_rd_len[LEN_W-1:0];
    end else begin
      w_pick_addr = w_pick[0] ? c_wr_addr[2*ADDR_W-1:ADDR_W] : c_wr_addr[ADDR_W-1:0];
      w_pick_len  = w_pick[0] ? c_wr_len[2*LEN_W-1:LEN_W]    : c_wr_len[LEN_W-1:0];
    end
  end

  assign w_rd      = r_grant[1];
  assign w_nz      = (r_len != '0);
  assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_BUSY);
  assign w_in_busy = (r_state == ST_BUSY);
  assign w_in_done = (r_state == ST_DONE);
  assign w_fin     = w_in_busy && (w_rd ? m_rd_burst_finish : m_wr_burst_finish);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= GNT_RD1;
      r_addr  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_rr_vld) begin
        r_grant <= w_pick;
        r_addr  <= w_pick_addr;
        r_len   <= w_pick_len;
        if (w_upd_last) r_last <= w_pick;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_rr_vld) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = w_nz ? ST_BUSY : ST_DONE;
      ST_BUSY:  if (w_fin) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign m_wr_burst_req  = w_active && w_nz && !w_rd;
  assign m_rd_burst_req  = w_active && w_nz &&  w_rd;
  assign m_wr_burst_len  = (w_active && !w_rd) ? r_len  : '0;
  assign m_rd_burst_len  = (w_active &&  w_rd) ? r_len  : '0;
  assign m_wr_burst_addr = (w_active && !w_rd) ? r_addr : '0;
  assign m_rd_burst_addr = (w_active &&  w_rd) ? r_addr : '0;
  assign m_wr_burst_data = (w_active && !w_rd)
                         ? (r_grant[0] ? c_wr_data[2*DATA_W-1:DATA_W] : c_wr_data[DATA_W-1:0])
                         : '0;

  // Data strobes only count while the engine owns the burst.
  assign c_wr_data_req   = (w_in_busy && !w_rd && m_wr_burst_data_req)   ? gnt_onehot(r_grant) : 2'b00;
  assign c_rd_data_valid = (w_in_busy &&  w_rd && m_rd_burst_data_valid) ? gnt_onehot(r_grant) : 2'b00;
  assign c_rd_data       = (w_in_busy &&  w_rd) ? m_rd_burst_data : '0;

  assign c_wr_finish = (w_in_done && !w_rd) ? gnt_onehot(r_grant) : 2'b00;
  assign c_rd_finish = (w_in_done &&  w_rd) ? gnt_onehot(r_grant) : 2'b00;

  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter; honours ARB_RD0_PRIORITY_EN when defined.
module tb_mem_burst_arbiter;
  localparam int DW = 64, AW = 24, LW = 10;

  logic          mem_clk = 1'b0, rst = 1'b0;
  logic [1:0]    c_wr_req = '0, c_rd_req = '0;
  logic [2*LW-1:0] c_wr_len = '0, c_rd_len = '0;
  logic [2*AW-1:0] c_wr_addr = '0, c_rd_addr = '0;
  logic [2*DW-1:0] c_wr_data = '0;
  logic [1:0]    c_wr_data_req, c_rd_data_valid, c_wr_finish, c_rd_finish;
  logic [DW-1:0] c_rd_data, m_wr_burst_data, m_rd_burst_data = '0;
  logic          m_wr_burst_req, m_rd_burst_req;
  logic [LW-1:0] m_wr_burst_len, m_rd_burst_len;
  logic [AW-1:0] m_wr_burst_addr, m_rd_burst_addr;
  logic          m_wr_burst_data_req = 0, m_rd_burst_data_valid = 0;
  logic          m_wr_burst_finish = 0, m_rd_burst_finish = 0;
  logic          busy;
  logic [1:0]    grant_id;

  int n_chk = 0, n_pass = 0;

  mem_burst_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .mem_clk(mem_clk), .rst(rst),
    .c_wr_req(c_wr_req), .c_rd_req(c_rd_req),
    .c_wr_len(c_wr_len), .c_rd_len(c_rd_len),
    .c_wr_addr(c_wr_addr), .c_rd_addr(c_rd_addr),
    .c_wr_data(c_wr_data),
    .c_wr_data_req(c_wr_data_req), .c_rd_data_valid(c_rd_data_valid),
    .c_rd_data(c_rd_data),
    .c_wr_finish(c_wr_finish), .c_rd_finish(c_rd_finish),
    .m_wr_burst_req(m_wr_burst_req), .m_rd_burst_req(m_rd_burst_req),
    .m_wr_burst_len(m_wr_burst_len), .m_rd_burst_len(m_rd_burst_len),
    .m_wr_burst_addr(m_wr_burst_addr), .m_rd_burst_addr(m_rd_burst_addr),
    .m_wr_burst_data(m_wr_burst_data),
    .m_wr_burst_data_req(m_wr_burst_data_req),
    .m_rd_burst_data_valid(m_rd_burst_data_valid),
    .m_wr_burst_finish(m_wr_burst_finish), .m_rd_burst_finish(m_rd_burst_finish),
    .m_rd_burst_data(m_rd_burst_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge mem_clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
  endtask

  // Engine model: wait for the master request, run one beat, finish, check the pulse and gap.
  task automatic serve(input logic [1:0] eg);
    int n;
    logic [1:0] oh;
    oh = eg[0] ? 2'b10 : 2'b01;
    n = 0;
    while (!(m_wr_burst_req || m_rd_burst_req) && n < 20) begin tick(); n++; end
    chk("grant", grant_id, eg);
    chk("mreq", {m_rd_burst_req, m_wr_burst_req}, eg[1] ? 2'b10 : 2'b01);
    tick();
    if (eg[1]) begin
      m_rd_burst_data_valid = 1'b1; m_rd_burst_data = 64'hD0 + eg; #1;
      chk("rdvalid", c_rd_data_valid, oh);
      chk("rddata", c_rd_data, 64'hD0 + eg);
    end else begin
      m_wr_burst_data_req = 1'b1; #1;
      chk("wdreq", c_wr_data_req, oh);
      chk("wdata", m_wr_burst_data, eg[0] ? 64'hBBBB : 64'hAAAA);
    end
    tick();
    m_rd_burst_data_valid = 1'b0; m_wr_burst_data_req = 1'b0;
    if (eg[1]) m_rd_burst_finish = 1'b1; else m_wr_burst_finish = 1'b1;
    tick();
    m_rd_burst_finish = 1'b0; m_wr_burst_finish = 1'b0; #1;
    chk("finish", eg[1] ? {c_rd_finish, c_wr_finish} : {c_wr_finish, c_rd_finish}, {oh, 2'b00});
    tick();
    chk("gap", busy, 1'b0);
  endtask

  initial begin
    int cnt;
    c_wr_data = {64'hBBBB, 64'hAAAA};
    c_wr_addr = {24'h000456, 24'h000123};
    c_rd_addr = {24'h000789, 24'h000abc};

    // Reset state
    rst = 1'b1; #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", grant_id, 2'd0);
    chk("rst_mreq", {m_rd_burst_req, m_wr_burst_req}, 2'b00);
    chk("rst_fin", {c_rd_finish, c_wr_finish}, 4'b0);
    tick(); rst = 1'b0;

    // wr0 alone, 16 beats; request dropped after grant
    c_wr_len = {10'd4, 10'd16};
    c_wr_req = 2'b01;
    tick();
    chk("w0_mreq", m_wr_burst_req, 1'b1);
    chk("w0_len", m_wr_burst_len, 10'd16);
    chk("w0_addr", m_wr_burst_addr, 24'h000123);
    chk("w0_busy", busy, 1'b1);
    c_wr_req = 2'b00;
    m_wr_burst_data_req = 1'b1; #1;
    chk("w0_issue_strobe", c_wr_data_req, 2'b00);
    tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (c_wr_data_req == 2'b01 && m_wr_burst_data == 64'hAAAA) cnt++;
      tick();
    end
    chk("w0_beats", cnt, 16);
    m_wr_burst_data_req = 1'b0; m_wr_burst_finish = 1'b1; #1;
    chk("w0_req_on_fin", m_wr_burst_req, 1'b1);
    tick();
    m_wr_burst_finish = 1'b0; #1;
    chk("w0_fin", c_wr_finish, 2'b01);
    chk("w0_req_off", m_wr_burst_req, 1'b0);
    tick();
    chk("w0_fin_once", c_wr_finish, 2'b00);
    chk("w0_idle", busy, 1'b0);

    // All four continuous, len 4
    do_reset();
    c_wr_len = {10'd4, 10'd4}; c_rd_len = {10'd4, 10'd4};
    c_wr_req = 2'b11; c_rd_req = 2'b11;
    serve(2'd0); serve(2'd1); serve(2'd2); serve(2'd3); serve(2'd0);
    c_wr_req = 2'b00; c_rd_req = 2'b00;
    tick(); tick(); tick(); tick(); tick();

    // rd0 with both writers continuous
    do_reset();
    c_wr_req = 2'b11; c_rd_req = 2'b01;
`ifdef ARB_RD0_PRIORITY_EN
    serve(2'd2); serve(2'd2); serve(2'd2);
`else
    serve(2'd0); serve(2'd1); serve(2'd2); serve(2'd0);
`endif
    c_wr_req = 2'b00; c_rd_req = 2'b00;
    tick(); tick(); tick(); tick(); tick();

    // rd1 with length 0
    do_reset();
    c_rd_len = {10'd0, 10'd4};
    c_rd_req = 2'b10;
    tick();
    chk("z_gnt", grant_id, 2'd3);
    chk("z_mreq", {m_rd_burst_req, m_wr_burst_req}, 2'b00);
    c_rd_req = 2'b00;
    tick();
    chk("z_fin", c_rd_finish, 2'b10);
    chk("z_mreq2", m_rd_burst_req, 1'b0);
    tick();
    chk("z_fin_once", c_rd_finish, 2'b00);

    // Reset mid write burst
    do_reset();
    c_wr_len = {10'd4, 10'd16}; c_rd_len = {10'd4, 10'd4};
    c_wr_req = 2'b01;
    tick(); tick();
    m_wr_burst_data_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; #1;
    chk("mr_mreq", m_wr_burst_req, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_wdreq", c_wr_data_req, 2'b00);
    chk("mr_gnt", grant_id, 2'd0);
    chk("mr_addr", m_wr_burst_addr, 24'h0);
    m_wr_burst_data_req = 1'b0;
    tick(); rst = 1'b0;
    c_wr_req = 2'b11; c_rd_req = 2'b11;
    tick();
    chk("mr_first", grant_id, 2'd0);
    chk("mr_first_req", m_wr_burst_req, 1'b1);
    c_wr_req = 2'b00; c_rd_req = 2'b00;
    tick();
    m_wr_burst_finish = 1'b1; tick(); m_wr_burst_finish = 1'b0; tick(); tick();

    // Spurious read finish during a write burst by wr1
    do_reset();
    c_wr_len = {10'd8, 10'd16};
    c_wr_req = 2'b10;
    tick();
    chk("sp_gnt", grant_id, 2'd1);
    c_wr_req = 2'b00;
    tick();
    m_rd_burst_finish = 1'b1; m_rd_burst_data_valid = 1'b1; #1;
    chk("sp_rdv", c_rd_data_valid, 2'b00);
    tick();
    m_rd_burst_finish = 1'b0; m_rd_burst_data_valid = 1'b0; #1;
    chk("sp_busy", busy, 1'b1);
    chk("sp_mreq", m_wr_burst_req, 1'b1);
    chk("sp_rfin", c_rd_finish, 2'b00);
    m_wr_burst_data_req = 1'b1; #1;
    chk("sp_wdreq", c_wr_data_req, 2'b10);
    chk("sp_wdata", m_wr_burst_data, 64'hBBBB);
    m_wr_burst_data_req = 1'b0; m_wr_burst_finish = 1'b1;
    tick();
    m_wr_burst_finish = 1'b0; #1;
    chk("sp_fin", c_wr_finish, 2'b10);
    tick();
    chk("sp_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
